// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : MIPS instruction-fetch stage. Owns the PC, drives the
//            combinational instruction memory and fills the IF/ID register.
//            Handles stall, flush, redirect and misaligned-fetch tagging.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h9fc00000,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc_q,         w_pc_d;
    logic [31:0] r_id_pc_q,      w_id_pc_d;
    logic [31:0] r_id_inst_q,    w_id_inst_d;
    logic        r_id_valid_q,   w_id_valid_d;
    logic        r_id_adel_q,    w_id_adel_d;
    logic        r_pend_valid_q, w_pend_valid_d;
    logic [31:0] r_pend_pc_q,    w_pend_pc_d;
    logic        w_misaligned;

    assign w_misaligned = (r_pc_q[1:0] != 2'b00);

    always_comb begin
        w_pc_d         = r_pc_q;
        w_id_pc_d      = r_id_pc_q;
        w_id_inst_d    = r_id_inst_q;
        w_id_valid_d   = r_id_valid_q;
        w_id_adel_d    = r_id_adel_q;
        w_pend_valid_d = r_pend_valid_q;
        w_pend_pc_d    = r_pend_pc_q;

        if (flush) begin
            w_id_pc_d      = r_pc_q;
            w_id_inst_d    = NOP_INST;
            w_id_valid_d   = 1'b0;
            w_id_adel_d    = 1'b0;
            w_pend_valid_d = 1'b0;
            if (redirect) begin
                w_pc_d = redirect_pc;
            end
        end else if (stall) begin
            // Redirects seen while stalled are parked; the latest one wins.
            if (redirect) begin
                w_pend_valid_d = 1'b1;
                w_pend_pc_d    = redirect_pc;
            end
        end else begin
            // The word fetched alongside a redirect is the delay slot and is kept.
            w_id_pc_d      = r_pc_q;
            w_id_valid_d   = 1'b1;
            w_id_adel_d    = w_misaligned;
            w_id_inst_d    = w_misaligned ? NOP_INST : im_data;
            w_pend_valid_d = 1'b0;
            if (redirect) begin
                w_pc_d = redirect_pc;
            end else if (r_pend_valid_q) begin
                w_pc_d = r_pend_pc_q;
            end else begin
                w_pc_d = r_pc_q + c_pc_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q         <= RESET_PC;
            r_id_pc_q      <= 32'h0;
            r_id_inst_q    <= NOP_INST;
            r_id_valid_q   <= 1'b0;
            r_id_adel_q    <= 1'b0;
            r_pend_valid_q <= 1'b0;
            r_pend_pc_q    <= 32'h0;
        end else begin
            r_pc_q         <= w_pc_d;
            r_id_pc_q      <= w_id_pc_d;
            r_id_inst_q    <= w_id_inst_d;
            r_id_valid_q   <= w_id_valid_d;
            r_id_adel_q    <= w_id_adel_d;
            r_pend_valid_q <= w_pend_valid_d;
            r_pend_pc_q    <= w_pend_pc_d;
        end
    end

    assign im_addr  = r_pc_q;
    assign id_pc    = r_id_pc_q;
    assign id_inst  = r_id_inst_q;
    assign id_valid = r_id_valid_q;
    assign id_adel  = r_id_adel_q;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter and drives the instruction memory address, then captures the returned word into the IF/ID pipeline register. The instruction memory reads combinationally, so this block issues the address and samples the data in the same cycle. It supports stall, flush, branch/jump redirect with a pending-redirect buffer for redirects that arrive while stalled, and misaligned-fetch (AdEL) tagging.

## Interface
Parameters:
- RESET_PC, 32'h9fc00000, PC value loaded on reset (boot ROM region).
- NOP_INST, 32'h00000000, instruction word injected for bubbles and faulting fetches.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- stall  input  1  hold PC and IF/ID register (hazard from ID or later).
- flush  input  1  invalidate IF/ID contents and drop the pending redirect (exception/eret).
- redirect  input  1  load redirect_pc as the next fetch PC.
- redirect_pc  input  32  target PC (branch/jump/exception vector).
- im_addr  output  32  fetch address to instruction memory, equal to current PC.
- im_data  input  32  instruction word returned combinationally for im_addr.
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_inst  output  32  instruction held in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- id_adel  output  1  IF/ID instruction came from a misaligned PC (pc[1:0] != 0).

## Operation
- State: pc (32), IF/ID register {id_pc, id_inst, id_valid, id_adel}, pend_valid (1), pend_pc (32).
- im_addr = pc, combinational, no other logic.
- Per-edge priority: rst > flush > stall > normal.
- rst: pc <= RESET_PC; id_pc <= 0; id_inst <= NOP_INST; id_valid <= 0; id_adel <= 0; pend_valid <= 0; pend_pc <= 0.
- flush (overrides stall): id_valid <= 0, id_inst <= NOP_INST, id_adel <= 0, id_pc <= pc; pend_valid <= 0; pc <= redirect ? redirect_pc : pc.
- stall and not flush: pc and IF/ID hold. If redirect: pend_pc <= redirect_pc, pend_valid <= 1. A later redirect during the same stall overwrites pend_pc; latest wins.
- normal (no stall, no flush): id_pc <= pc; id_valid <= 1; if pc[1:0] != 0 then id_inst <= NOP_INST, id_adel <= 1, else id_inst <= im_data, id_adel <= 0. Next pc: redirect ? redirect_pc : (pend_valid ? pend_pc : pc + 4). pend_valid <= 0.
- A live redirect takes precedence over a buffered pending one.
- The instruction fetched in the cycle redirect is asserted is captured normally. This is the branch delay slot and is never squashed by redirect alone.
- pc + 4 is modulo 2^32: 32'hfffffffc wraps to 32'h00000000.
- Misaligned redirect_pc is accepted as-is. The fault is reported only via id_adel when that PC is fetched. Sequencing continues at pc + 4 from the misaligned value.

## Timing
- Fetch latency: address issued in cycle N, instruction visible on id_inst after edge N+1 (one IF/ID stage).
- Redirect asserted in cycle N (unstalled): im_addr = redirect_pc in cycle N+1.
- Redirect during stall: im_addr = pend_pc in the cycle after the first unstalled edge. That is, the first unstalled edge captures the held instruction and loads pend_pc.
- After reset deassert: im_addr = RESET_PC in the first cycle, and id_valid first rises after the following edge.
- All outputs except im_addr are registered. im_addr changes only on clock edges.

## Test plan
- Reset then 4 free-running cycles with im_data = 32'h24010001 -> id_pc sequence 9fc00000, 9fc00004, 9fc00008, id_valid = 1 from the second edge, id_inst = 24010001.
- Redirect to 32'h80000000 while pc = 9fc00008 -> id_pc = 9fc00008 (delay slot, valid), next im_addr = 80000000, then 80000004.
- Stall held 3 cycles at pc = 80000004 with redirect to 80000100 on stall cycle 2 -> pc and IF/ID frozen, first unstalled edge captures 80000004, next im_addr = 80000100.
- Flush together with stall and redirect to 32'hbfc00380 -> id_valid = 0, id_inst = NOP_INST, pending cleared, im_addr = bfc00380 next cycle.
- Redirect to 32'h80000002 -> following capture has id_adel = 1, id_inst = NOP_INST, id_pc = 80000002, next im_addr = 80000006.
- rst asserted mid-stall with pend_valid = 1 -> all outputs return to reset values, im_addr = 9fc00000, pending redirect discarded.
